// File: rtl/ahb_sevenseg_mux.sv
// ---------------------------------------------------------------------------
// ahb_sevenseg_mux
//   AHB-Lite slave driving a multiplexed, active-low seven-segment display.
//   Programmer registers (DATA, DP, CTRL) are copied into display shadows only
//   at a scan-frame boundary, so the display never shows a half-written value.
//
// Ports
//   CLK        : system clock, rising edge
//   RESET      : asynchronous, active-high reset
//   HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA : AHB-Lite slave inputs
//   HRDATA     : read data (combinational in the data phase)
//   HREADYOUT  : always 1 (zero wait states)
//   seg        : active-low segments, bit0 = a ... bit6 = g (registered)
//   dp         : active-low decimal point (registered)
//   an         : active-low one-hot digit enables (registered)
//
// Register map (HADDR[3:2])
//   0 DATA   : nibble per digit, digit i = bits [4i+3:4i]
//   1 DP     : bit i lights the point on digit i
//   2 CTRL   : bit0 EN, bits [NUM_DIGITS+7:8] BLANK mask
//   3 STATUS : bits [2:0] current digit index, bit8 shadow-pending (read-only)
// ---------------------------------------------------------------------------
module ahb_sevenseg_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int              DW       = 4 * NUM_DIGITS;
  localparam int              CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]      IDX_LAST = 3'(NUM_DIGITS - 1);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_DP   = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  // Active-low hex decode, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      4'hF:    hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  // Bus pipeline
  logic                  addr_valid_q, addr_valid_d;
  logic                  addr_write_q, addr_write_d;
  logic [1:0]            addr_reg_q,   addr_reg_d;
  // Programmer-visible registers
  logic [DW-1:0]         data_q,  data_d;
  logic [NUM_DIGITS-1:0] dpm_q,   dpm_d;
  logic                  en_q,    en_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  // Display shadows
  logic [DW-1:0]         sh_data_q,  sh_data_d;
  logic [NUM_DIGITS-1:0] sh_dpm_q,   sh_dpm_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
  logic                  pend_q, pend_d;
  // Scan position
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  // Registered display outputs
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q,  dp_d;
  logic [NUM_DIGITS-1:0] an_q,  an_d;

  logic                  sample_s, wr_s, wr_vis_s, tc_s, frame_s;
  logic [3:0]            nib_s;
  logic                  pt_s, blk_s;
  logic [NUM_DIGITS-1:0] digit_an_s;
  logic [31:0]           rdata_s;
  logic                  unused_s;

  assign sample_s = HSEL & HREADY & HTRANS[1];
  assign wr_s     = addr_valid_q & addr_write_q;
  assign wr_vis_s = wr_s & (addr_reg_q != A_STAT);
  assign tc_s     = (cnt_q == CNT_LAST);
  assign frame_s  = tc_s & (idx_q == IDX_LAST);
  assign unused_s = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

  // Address-phase capture and data-phase register writes.
  always_comb begin
    addr_valid_d = sample_s;
    addr_write_d = sample_s ? HWRITE     : addr_write_q;
    addr_reg_d   = sample_s ? HADDR[3:2] : addr_reg_q;
    data_d       = data_q;
    dpm_d        = dpm_q;
    en_d         = en_q;
    blank_d      = blank_q;
    case ({wr_s, addr_reg_q})
      {1'b1, A_DATA}: data_d = HWDATA[DW-1:0];
      {1'b1, A_DP}:   dpm_d  = HWDATA[NUM_DIGITS-1:0];
      {1'b1, A_CTRL}: begin
        en_d    = HWDATA[0];
        blank_d = HWDATA[NUM_DIGITS+7:8];
      end
      default: data_d = data_q;  // no write, or STATUS (read-only)
    endcase
  end

  // Scan counter, shadow copy at frame boundary and pending flag.
  always_comb begin
    cnt_d = tc_s ? {CW{1'b0}} : cnt_q + CW'(1'b1);
    if (tc_s) begin
      idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
    // The copy uses the current (pre-write) register values.
    sh_data_d  = frame_s ? data_q  : sh_data_q;
    sh_dpm_d   = frame_s ? dpm_q   : sh_dpm_q;
    sh_blank_d = frame_s ? blank_q : sh_blank_q;
    // A write coinciding with the copy keeps the flag set for the next frame.
    if (wr_vis_s) begin
      pend_d = 1'b1;
    end else if (frame_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Select the current digit's shadow fields and form the next display outputs.
  always_comb begin
    nib_s      = 4'h0;
    pt_s       = 1'b0;
    blk_s      = 1'b1;
    digit_an_s = {NUM_DIGITS{1'b1}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        nib_s         = sh_data_q[4*i +: 4];
        pt_s          = sh_dpm_q[i];
        blk_s         = sh_blank_q[i];
        digit_an_s[i] = 1'b0;
      end else begin
        digit_an_s[i] = 1'b1;
      end
    end
    if (en_q && !blk_s) begin
      seg_d = hex7(nib_s);
      dp_d  = ~pt_s;
      an_d  = digit_an_s;
    end else begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      an_d  = {NUM_DIGITS{1'b1}};
    end
  end

  // Read mux, driven from the registered address during a read data phase.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case ({addr_valid_q & ~addr_write_q, addr_reg_q})
      {1'b1, A_DATA}: rdata_s[DW-1:0]         = data_q;
      {1'b1, A_DP}:   rdata_s[NUM_DIGITS-1:0] = dpm_q;
      {1'b1, A_CTRL}: begin
        rdata_s[0]              = en_q;
        rdata_s[NUM_DIGITS+7:8] = blank_q;
      end
      {1'b1, A_STAT}: begin
        rdata_s[2:0] = idx_q;
        rdata_s[8]   = pend_q;
      end
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  // State registers; reset aborts any transfer in flight and blanks the display.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_valid_q <= 1'b0;
      addr_write_q <= 1'b0;
      addr_reg_q   <= 2'd0;
      data_q       <= {DW{1'b0}};
      dpm_q        <= {NUM_DIGITS{1'b0}};
      en_q         <= 1'b0;
      blank_q      <= {NUM_DIGITS{1'b0}};
      sh_data_q    <= {DW{1'b0}};
      sh_dpm_q     <= {NUM_DIGITS{1'b0}};
      sh_blank_q   <= {NUM_DIGITS{1'b0}};
      pend_q       <= 1'b0;
      cnt_q        <= {CW{1'b0}};
      idx_q        <= 3'd0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= {NUM_DIGITS{1'b1}};
    end else begin
      addr_valid_q <= addr_valid_d;
      addr_write_q <= addr_write_d;
      addr_reg_q   <= addr_reg_d;
      data_q       <= data_d;
      dpm_q        <= dpm_d;
      en_q         <= en_d;
      blank_q      <= blank_d;
      sh_data_q    <= sh_data_d;
      sh_dpm_q     <= sh_dpm_d;
      sh_blank_q   <= sh_blank_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign HRDATA    = rdata_s;
  assign HREADYOUT = 1'b1;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;

endmodule

// File: tb/tb_ahb_sevenseg_mux.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ahb_sevenseg_mux (NUM_DIGITS = 4, REFRESH_DIV = 4).
// Stimulus pushes expected read data and expected display states (tagged with
// the bench cycle number) into queues; a monitor pops and compares them.
// Bench cycle k = number of rising edges since reset release. After edge k the
// DUT's scan position is cnt = k%4, idx = (k/4)%4; the registered outputs show
// the digit for idx = ((k-1)/4)%4. Frame-boundary copies happen at edges 16,32,...
// ---------------------------------------------------------------------------
module tb_ahb_sevenseg_mux;

  localparam int ND = 4;
  localparam int RD = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;

  ahb_sevenseg_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .seg(seg), .dp(dp), .an(an)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  logic rd_dph;

  typedef struct { int cyc; logic [11:0] exp; } disp_t;
  disp_t       disp_q[$];
  logic [31:0] rd_exp_q[$];
  string       rd_tag_q[$];

  // Bench cycle count and read data-phase tracking from the bus signals.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cyc    <= 0;
      rd_dph <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      rd_dph <= HSEL & HREADY & HTRANS[1] & ~HWRITE;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Hand-written active-low hex table.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Expected {an, seg, dp} after edge k for the given shadow contents.
  function automatic logic [11:0] disp_exp(input int k, input logic [15:0] v,
                                           input logic [3:0] blk, input logic [3:0] pt,
                                           input logic en);
    int d;
    logic [3:0] a;
    d = ((k - 1) / 4) % 4;
    if (!en || blk[d]) return {4'hF, 7'h7F, 1'b1};
    a = 4'hF;
    a[d] = 1'b0;
    return {a, seg7(v[4*d +: 4]), ~pt[d]};
  endfunction

  task automatic push_disp(input int c0, input int c1, input logic [15:0] v,
                           input logic [3:0] blk, input logic [3:0] pt, input logic en);
    disp_t e;
    for (int k = c0; k <= c1; k++) begin
      e.cyc = k;
      e.exp = disp_exp(k, v, blk, pt, en);
      disp_q.push_back(e);
    end
  endtask

  // Monitor: compares read data in each read data phase and display state on tagged cycles.
  initial begin
    disp_t d;
    logic [31:0] e;
    string t;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (rd_dph) begin
          if (rd_exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_unexpected: got %h, expected no read", HRDATA);
          end else begin
            e = rd_exp_q.pop_front();
            t = rd_tag_q.pop_front();
            check(t, HRDATA, e);
          end
        end
        while (disp_q.size() > 0 && disp_q[0].cyc <= cyc) begin
          d = disp_q.pop_front();
          if (d.cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL disp_missed: cycle %0d, expected %h", d.cyc, d.exp);
          end else begin
            check($sformatf("disp@%0d {an,seg,dp}", cyc), {20'h0, an, seg, dp}, {20'h0, d.exp});
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    if (cyc > c) begin
      n_bad++;
      $display("FAIL sched: at cycle %0d, expected <= %0d", cyc, c);
    end
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
  endtask

  // Write committed at rising edge c.
  task automatic bus_write(input int c, input logic [1:0] a, input logic [31:0] d);
    wait_cyc(c - 2);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a, 2'b00};
    @(negedge CLK);
    bus_idle();
    HWDATA = d;
  endtask

  // Read whose data phase follows rising edge c.
  task automatic bus_read(input int c, input logic [1:0] a, input logic [31:0] e, input string t);
    wait_cyc(c - 1);
    rd_exp_q.push_back(e);
    rd_tag_q.push_back(t);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a, 2'b00};
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},  {28'h0, an},  32'h0000_000F);
    check({tag, "_seg"}, {25'h0, seg}, 32'h0000_007F);
    check({tag, "_dp"},  {31'h0, dp},  32'h0000_0001);
  endtask

  initial begin
    repeat (5000) @(posedge CLK);
    $display("FAIL watchdog: cycle budget exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    HREADY = 1'b1;
    HWDATA = 32'h0;
    RESET  = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("rst_hrdata", HRDATA, 32'h0);
    RESET = 1'b0;

    // Reset values, display dark with EN = 0
    push_disp(2, 8, 16'h0, 4'h0, 4'h0, 1'b0);
    bus_read(1, 2'd3, 32'h0, "rst_status");
    bus_read(3, 2'd0, 32'h0, "rst_data");
    bus_read(5, 2'd1, 32'h0, "rst_dp");
    bus_read(7, 2'd2, 32'h0, "rst_ctrl");

    // Scan: EN immediate (old shadow 0 on digit 3), new data after boundary at 16
    push_disp(10, 12, 16'h0, 4'h0, 4'h0, 1'b0);
    push_disp(13, 16, 16'h0, 4'h0, 4'h0, 1'b1);
    push_disp(17, 32, 16'h1234, 4'h0, 4'h0, 1'b1);
    bus_write(10, 2'd0, 32'h0000_1234);
    bus_write(12, 2'd2, 32'h0000_0001);
    bus_read(14, 2'd3, 32'h0000_0103, "status_pending");
    bus_read(18, 2'd3, 32'h0000_0000, "status_cleared");

    // Tear-free: mid-frame write shows only after the boundary at 48
    push_disp(33, 48, 16'h1234, 4'h0, 4'h0, 1'b1);
    push_disp(49, 64, 16'h5678, 4'h0, 4'h0, 1'b1);
    bus_write(38, 2'd0, 32'h0000_5678);
    bus_read(40, 2'd0, 32'h0000_5678, "data_readback");
    bus_read(44, 2'd3, 32'h0000_0103, "tear_status_pending");
    bus_read(50, 2'd3, 32'h0000_0000, "tear_status_cleared");

    // Blank digit 1, point on digit 0
    push_disp(65, 80, 16'h5678, 4'b0010, 4'b0001, 1'b1);
    bus_write(54, 2'd2, 32'h0000_0201);
    bus_write(56, 2'd1, 32'h0000_0001);
    bus_read(58, 2'd2, 32'h0000_0201, "ctrl_readback");
    bus_read(60, 2'd1, 32'h0000_0001, "dp_readback");

    // Collision: write on boundary edge 80, copy takes the pre-write value
    push_disp(81, 96, 16'h0F0E, 4'b0010, 4'b0001, 1'b1);
    push_disp(97, 112, 16'h9ABC, 4'b0010, 4'b0001, 1'b1);
    bus_write(70, 2'd0, 32'h0000_0F0E);
    bus_write(80, 2'd0, 32'h0000_9ABC);
    bus_read(82, 2'd3, 32'h0000_0100, "collision_pending");
    bus_read(86, 2'd0, 32'h0000_9ABC, "collision_data");
    bus_read(98, 2'd3, 32'h0000_0000, "collision_cleared");

    // Reset between address and data phase of a write
    wait_cyc(116);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    bus_idle();
    HWDATA = 32'hFFFF_FFFF;
    @(negedge CLK);
    check_reset_outputs("midrst1");
    @(negedge CLK);
    check_reset_outputs("midrst2");
    RESET = 1'b0;
    push_disp(2, 6, 16'h0, 4'h0, 4'h0, 1'b0);
    push_disp(7, 12, 16'h0, 4'h0, 4'h0, 1'b1);
    bus_read(1, 2'd0, 32'h0, "data_after_rst");
    bus_read(3, 2'd3, 32'h0, "status_after_rst");
    bus_write(6, 2'd2, 32'h0000_0001);
    wait_cyc(14);

    if (rd_exp_q.size() != 0 || disp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d reads and %0d display entries pending, expected 0",
               rd_exp_q.size(), disp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
